// File: rtl/trigger_ctrl_pkg.sv
// rtl/trigger_ctrl_pkg.sv - shared encodings for the trigger sequencer
// Purpose: FSM state encoding, run status codes and generator level-select codes.
// Ports: none (package).
package trigger_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD_A   = 4'd1,
    S_LOAD_B   = 4'd2,
    S_GEN_RST  = 4'd3,
    S_WAIT_ARM = 4'd4,
    S_WAIT_A   = 4'd5,
    S_WAIT_B   = 4'd6,
    S_WAIT_END = 4'd7,
    S_REPORT   = 4'd8
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  localparam logic [1:0] LVL_ADD_NONE = 2'b00;
  localparam logic [1:0] LVL_ADD_A    = 2'b01;
  localparam logic [1:0] LVL_ADD_B    = 2'b10;

endpackage

// File: rtl/trig_edge_det.sv
// rtl/trig_edge_det.sv - registered rise/fall detector for one trigger input
// Purpose: one delay flop; rise/fall compare the live input against it.
// Ports: clk, rst (sync active-high), sig_in; rise, fall (same-cycle pulses).
module trig_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic in_d_q;
  logic in_d_d;

  always_comb in_d_d = sig_in;

  always_ff @(posedge clk) begin
    if (rst) in_d_q <= 1'b0;
    else     in_d_q <= in_d_d;
  end

  assign rise = sig_in & ~in_d_q;
  assign fall = ~sig_in & in_d_q;

endmodule

// File: rtl/trigger_ctrl.sv
// rtl/trigger_ctrl.sv - trigger-run sequencer for the two-channel trigger generator
// Purpose: accept a run command, load A/B levels, reset the generator, supervise
//   trigger0/trigger1 events, then report status and the A->B delay.
// Ports: adc_clk/adc_reset; cmd_* handshake with levels and watchdog; abort;
//   gen_reset/gen_level_add/gen_level to the generator; trigger0/1 from it;
//   busy, done_valid, done_status, delay_cnt results.
module trigger_ctrl
  import trigger_ctrl_pkg::*;
#(
  parameter int LEVEL_WIDTH = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int RST_CYCLES  = 4
) (
  input  logic                   adc_clk,
  input  logic                   adc_reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LEVEL_WIDTH-1:0] cmd_level_a,
  input  logic [LEVEL_WIDTH-1:0] cmd_level_b,
  input  logic [CNT_WIDTH-1:0]   cmd_timeout,
  input  logic                   abort,
  output logic                   gen_reset,
  output logic [1:0]             gen_level_add,
  output logic [LEVEL_WIDTH-1:0] gen_level,
  input  logic                   trigger0,
  input  logic                   trigger1,
  output logic                   busy,
  output logic                   done_valid,
  output logic [1:0]             done_status,
  output logic [CNT_WIDTH-1:0]   delay_cnt
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t                 state_q, state_d;
  logic [RC_W-1:0]        rst_cnt_q, rst_cnt_d;
  logic [CNT_WIDTH-1:0]   wd_q, wd_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [LEVEL_WIDTH-1:0] lvl_b_q, lvl_b_d;
  logic [CNT_WIDTH-1:0]   timeout_q, timeout_d;
  logic                   gen_reset_q, gen_reset_d;
  logic [1:0]             gen_level_add_q, gen_level_add_d;
  logic [LEVEL_WIDTH-1:0] gen_level_q, gen_level_d;
  logic                   busy_q, busy_d;
  logic                   done_valid_q, done_valid_d;
  logic [1:0]             done_status_q, done_status_d;
  logic [CNT_WIDTH-1:0]   delay_cnt_q, delay_cnt_d;

  logic       t0_rise, t0_fall, t1_rise, t1_fall;
  logic       accept, in_wait, wd_expire, rst_last, abort_ok;
  logic [1:0] term_status;

  trig_edge_det u_edge_t0 (.clk(adc_clk), .rst(adc_reset), .sig_in(trigger0),
                           .rise(t0_rise), .fall(t0_fall));
  trig_edge_det u_edge_t1 (.clk(adc_clk), .rst(adc_reset), .sig_in(trigger1),
                           .rise(t1_rise), .fall(t1_fall));

  assign cmd_ready = (state_q == S_IDLE) && !adc_reset;
  assign accept    = cmd_valid && cmd_ready;
  assign in_wait   = (state_q == S_WAIT_ARM) || (state_q == S_WAIT_A) ||
                     (state_q == S_WAIT_B)   || (state_q == S_WAIT_END);
  // wd_q == 1 implies nonzero, so a zero (disabled) watchdog never expires
  assign wd_expire = in_wait && (wd_q == CNT_WIDTH'(1));
  assign rst_last  = (rst_cnt_q == RC_W'(RST_CYCLES - 1));
  assign abort_ok  = abort && (state_q != S_IDLE) && (state_q != S_REPORT);

  // State register
  always_ff @(posedge adc_clk) begin
    if (adc_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state: abort beats timeout beats edge transitions
  always_comb begin
    state_d     = state_q;
    term_status = ST_OK;
    if (abort_ok) begin
      state_d     = S_REPORT;
      term_status = ST_ABORT;
    end else if (wd_expire) begin
      state_d     = S_REPORT;
      term_status = ST_TIMEOUT;
    end else begin
      case (state_q)
        S_IDLE:     if (accept) state_d = S_LOAD_A;
        S_LOAD_A:   state_d = S_LOAD_B;
        S_LOAD_B:   state_d = S_GEN_RST;
        S_GEN_RST:  if (rst_last) state_d = S_WAIT_ARM;
        S_WAIT_ARM: if (t0_rise) state_d = S_WAIT_A;
        S_WAIT_A:   if (t0_fall) state_d = t1_rise ? S_WAIT_END : S_WAIT_B;
        S_WAIT_B:   if (t1_rise) state_d = S_WAIT_END;
        S_WAIT_END: if (t1_fall) state_d = S_REPORT;
        S_REPORT:   state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered outputs, keyed on the state being entered
  always_comb begin
    lvl_b_d   = lvl_b_q;
    timeout_d = timeout_q;
    if (accept) begin
      lvl_b_d   = cmd_level_b;
      timeout_d = cmd_timeout;
    end

    rst_cnt_d = (state_q == S_GEN_RST) ? rst_cnt_q + RC_W'(1) : '0;

    wd_d = wd_q;
    if (state_q == S_GEN_RST && rst_last) wd_d = timeout_q;
    else if (in_wait && wd_q != '0)       wd_d = wd_q - CNT_WIDTH'(1);

    // A event seeds the counter; a coincident B event means zero delay
    cnt_d = cnt_q;
    if (state_q == S_WAIT_A && t0_fall)
      cnt_d = t1_rise ? '0 : CNT_WIDTH'(1);
    else if (state_q == S_WAIT_B && !t1_rise && !(&cnt_q))
      cnt_d = cnt_q + CNT_WIDTH'(1);

    gen_level_add_d = LVL_ADD_NONE;
    gen_level_d     = gen_level_q;
    if (state_d == S_LOAD_A) begin
      gen_level_add_d = LVL_ADD_A;
      gen_level_d     = cmd_level_a;  // only reached on accept, same cycle as latch
    end else if (state_d == S_LOAD_B) begin
      gen_level_add_d = LVL_ADD_B;
      gen_level_d     = lvl_b_q;
    end

    gen_reset_d   = (state_d == S_GEN_RST) ||
                    (state_d == S_REPORT && term_status != ST_OK);
    busy_d        = (state_d != S_IDLE);
    done_valid_d  = (state_d == S_REPORT);
    done_status_d = done_status_q;
    delay_cnt_d   = delay_cnt_q;
    if (state_d == S_REPORT) begin
      done_status_d = term_status;
      delay_cnt_d   = (term_status == ST_OK) ? cnt_q : '0;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (adc_reset) begin
      rst_cnt_q       <= '0;
      wd_q            <= '0;
      cnt_q           <= '0;
      lvl_b_q         <= '0;
      timeout_q       <= '0;
      gen_reset_q     <= 1'b1;
      gen_level_add_q <= LVL_ADD_NONE;
      gen_level_q     <= '0;
      busy_q          <= 1'b0;
      done_valid_q    <= 1'b0;
      done_status_q   <= ST_OK;
      delay_cnt_q     <= '0;
    end else begin
      rst_cnt_q       <= rst_cnt_d;
      wd_q            <= wd_d;
      cnt_q           <= cnt_d;
      lvl_b_q         <= lvl_b_d;
      timeout_q       <= timeout_d;
      gen_reset_q     <= gen_reset_d;
      gen_level_add_q <= gen_level_add_d;
      gen_level_q     <= gen_level_d;
      busy_q          <= busy_d;
      done_valid_q    <= done_valid_d;
      done_status_q   <= done_status_d;
      delay_cnt_q     <= delay_cnt_d;
    end
  end

  assign gen_reset     = gen_reset_q;
  assign gen_level_add = gen_level_add_q;
  assign gen_level     = gen_level_q;
  assign busy          = busy_q;
  assign done_valid    = done_valid_q;
  assign done_status   = done_status_q;
  assign delay_cnt     = delay_cnt_q;

endmodule

// File: tb/tb_trigger_ctrl.sv
// tb/tb_trigger_ctrl.sv - scoreboard bench for trigger_ctrl
module tb_trigger_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        adc_reset, cmd_valid, cmd_ready, abort, trigger0, trigger1;
  logic [15:0] cmd_level_a, cmd_level_b, gen_level;
  logic [31:0] cmd_timeout, delay_cnt;
  logic        gen_reset, busy, done_valid;
  logic [1:0]  gen_level_add, done_status;

  logic        s_cmd_valid, s_cmd_ready, s_abort, s_trigger0, s_trigger1;
  logic [15:0] s_cmd_level_a, s_cmd_level_b, s_gen_level;
  logic [3:0]  s_cmd_timeout, s_delay_cnt;
  logic        s_gen_reset, s_busy, s_done_valid;
  logic [1:0]  s_gen_level_add, s_done_status;

  trigger_ctrl #(.LEVEL_WIDTH(16), .CNT_WIDTH(32), .RST_CYCLES(4)) dut (
    .adc_clk(clk), .adc_reset(adc_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_level_a(cmd_level_a), .cmd_level_b(cmd_level_b), .cmd_timeout(cmd_timeout),
    .abort(abort), .gen_reset(gen_reset), .gen_level_add(gen_level_add),
    .gen_level(gen_level), .trigger0(trigger0), .trigger1(trigger1), .busy(busy),
    .done_valid(done_valid), .done_status(done_status), .delay_cnt(delay_cnt));

  trigger_ctrl #(.LEVEL_WIDTH(16), .CNT_WIDTH(4), .RST_CYCLES(4)) dut_sat (
    .adc_clk(clk), .adc_reset(adc_reset), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_level_a(s_cmd_level_a), .cmd_level_b(s_cmd_level_b), .cmd_timeout(s_cmd_timeout),
    .abort(s_abort), .gen_reset(s_gen_reset), .gen_level_add(s_gen_level_add),
    .gen_level(s_gen_level), .trigger0(s_trigger0), .trigger1(s_trigger1), .busy(s_busy),
    .done_valid(s_done_valid), .done_status(s_done_status), .delay_cnt(s_delay_cnt));

  typedef struct { logic [1:0] st; logic [31:0] dly; int at; } done_t;
  typedef struct { logic [1:0] add; logic [15:0] lvl; int at; } lvl_t;

  done_t exp_done[$];
  done_t exp_sdone[$];
  lvl_t  exp_lvl[$];
  int    exp_rst[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_done(input logic [1:0] st, input logic [31:0] dly, input int at);
    done_t d;
    d.st = st; d.dly = dly; d.at = at;
    exp_done.push_back(d);
  endtask

  // Offer a command on the main DUT; returns the cycle c in which it is accepted
  task automatic issue(input logic [15:0] la, input logic [15:0] lb,
                       input logic [31:0] to, output int a);
    int   k;
    lvl_t l;
    k = 0;
    while (!cmd_ready && k < 50) begin
      step(1);
      k++;
    end
    chk("cmd_ready_before_issue", cmd_ready, 1'b1);
    cmd_level_a = la; cmd_level_b = lb; cmd_timeout = to; cmd_valid = 1'b1;
    a = cyc;
    l.add = 2'b01; l.lvl = la; l.at = a + 1; exp_lvl.push_back(l);
    l.add = 2'b10; l.lvl = lb; l.at = a + 2; exp_lvl.push_back(l);
    exp_rst.push_back(4);
    step(1);
    cmd_valid = 1'b0;
  endtask

  // Monitors: compare against scoreboards whenever the DUTs present output
  done_t md;
  lvl_t  ml;
  int    run_len = 0;
  bit    run_rst = 1'b0;
  int    s_load_cnt = 0;
  int    exp_len;

  always @(negedge clk) begin
    if (!adc_reset && done_valid === 1'b1) begin
      if (exp_done.size() == 0) chk("unexpected_done_valid", 1'b1, 1'b0);
      else begin
        md = exp_done.pop_front();
        chk("done_status", done_status, md.st);
        chk("delay_cnt", delay_cnt, md.dly);
        chk("done_cycle", cyc, md.at);
      end
    end
    if (!adc_reset && gen_level_add !== 2'b00) begin
      if (exp_lvl.size() == 0) chk("unexpected_level_load", gen_level_add, 2'b00);
      else begin
        ml = exp_lvl.pop_front();
        chk("gen_level_add", gen_level_add, ml.add);
        chk("gen_level", gen_level, ml.lvl);
        chk("level_cycle", cyc, ml.at);
      end
    end
    if (gen_reset === 1'b1) begin
      run_len++;
      if (adc_reset) run_rst = 1'b1;
    end else if (run_len > 0) begin
      if (!run_rst) begin
        if (exp_rst.size() == 0) chk("unexpected_gen_reset", run_len, 0);
        else begin
          exp_len = exp_rst.pop_front();
          chk("gen_reset_len", run_len, exp_len);
        end
      end
      run_len = 0;
      run_rst = 1'b0;
    end
    if (!adc_reset && s_done_valid === 1'b1) begin
      if (exp_sdone.size() == 0) chk("sat_unexpected_done", 1'b1, 1'b0);
      else begin
        md = exp_sdone.pop_front();
        chk("sat_done_status", s_done_status, md.st);
        chk("sat_delay_cnt", s_delay_cnt, md.dly);
        chk("sat_done_cycle", cyc, md.at);
      end
    end
    if (!adc_reset && s_gen_level_add !== 2'b00) s_load_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int   a;
    done_t d;
    adc_reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; trigger0 = 1'b0; trigger1 = 1'b0;
    cmd_level_a = '0; cmd_level_b = '0; cmd_timeout = '0;
    s_cmd_valid = 1'b0; s_abort = 1'b0; s_trigger0 = 1'b0; s_trigger1 = 1'b0;
    s_cmd_level_a = '0; s_cmd_level_b = '0; s_cmd_timeout = '0;
    step(3);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_gen_reset", gen_reset, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done_valid", done_valid, 1'b0);
    chk("rst_gen_level_add", gen_level_add, 2'b00);
    chk("rst_gen_level", gen_level, 16'h0);
    chk("rst_delay_cnt", delay_cnt, 32'h0);
    adc_reset = 1'b0;
    step(1);
    chk("post_rst_gen_reset", gen_reset, 1'b0);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Normal run: A->B delay of 50
    issue(16'h0100, 16'hFF00, 32'd1000, a);
    step(6);
    step(20); trigger0 = 1'b1;
    step(30); trigger0 = 1'b0;
    chk("busy_in_run", busy, 1'b1);
    step(50); trigger1 = 1'b1;
    step(4);  trigger1 = 1'b0;
    push_done(2'b00, 32'd50, cyc + 1);
    step(3);
    chk("gen_level_holds", gen_level, 16'hFF00);
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    // Timeout: done 100 cycles after WAIT_ARM entry (a+7)
    issue(16'h0010, 16'h0020, 32'd100, a);
    push_done(2'b01, 32'd0, a + 107);
    exp_rst.push_back(1);
    step(115);

    // Coincident A fall and B rise
    issue(16'h7FFF, 16'h8000, 32'd1000, a);
    step(6);
    step(3); trigger0 = 1'b1;
    step(4); trigger0 = 1'b0; trigger1 = 1'b1;
    step(2); trigger1 = 1'b0;
    push_done(2'b00, 32'd0, cyc + 1);
    step(3);

    // Abort in WAIT_B, same cycle as trigger1 rise
    issue(16'h0001, 16'hFFFF, 32'd1000, a);
    step(6);
    step(2); trigger0 = 1'b1;
    step(3); trigger0 = 1'b0;
    step(6); trigger1 = 1'b1; abort = 1'b1;
    push_done(2'b10, 32'd0, cyc + 1);
    exp_rst.push_back(1);
    step(1); abort = 1'b0; trigger1 = 1'b0;
    step(3);
    chk("abort_status_held", done_status, 2'b10);

    // adc_reset during WAIT_A
    issue(16'h0AAA, 16'h0BBB, 32'd1000, a);
    step(6);
    step(2); trigger0 = 1'b1;
    step(2); adc_reset = 1'b1; trigger0 = 1'b0;
    step(1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b0);
    chk("midrst_gen_reset", gen_reset, 1'b1);
    chk("midrst_gen_level_add", gen_level_add, 2'b00);
    chk("midrst_gen_level", gen_level, 16'h0);
    chk("midrst_done_valid", done_valid, 1'b0);
    chk("midrst_done_status", done_status, 2'b00);
    chk("midrst_delay_cnt", delay_cnt, 32'h0);
    step(1); adc_reset = 1'b0;
    step(1);
    issue(16'h0123, 16'h0456, 32'd50, a);
    step(6);
    step(2); trigger0 = 1'b1;
    step(3); trigger0 = 1'b0;
    step(7); trigger1 = 1'b1;
    step(2); trigger1 = 1'b0;
    push_done(2'b00, 32'd7, cyc + 1);
    step(3);

    // Saturation on the 4-bit instance, plus a command offered while busy
    chk("sat_cmd_ready_idle", s_cmd_ready, 1'b1);
    s_cmd_level_a = 16'h1234; s_cmd_level_b = 16'h5678; s_cmd_timeout = 4'd0; s_cmd_valid = 1'b1;
    step(1); s_cmd_valid = 1'b0;
    step(6);
    step(3); s_trigger0 = 1'b1;
    step(3); s_trigger0 = 1'b0;
    step(2); s_cmd_valid = 1'b1;
    chk("sat_busy_not_ready", s_cmd_ready, 1'b0);
    step(3);
    chk("sat_busy_not_ready2", s_cmd_ready, 1'b0);
    s_cmd_valid = 1'b0;
    step(35); s_trigger1 = 1'b1;
    step(2);  s_trigger1 = 1'b0;
    d.st = 2'b00; d.dly = 32'd15; d.at = cyc + 1;
    exp_sdone.push_back(d);
    step(3);
    chk("sat_level_loads", s_load_cnt, 2);
    chk("sat_busy_after", s_busy, 1'b0);

    step(5);
    chk("done_queue_empty", exp_done.size(), 0);
    chk("level_queue_empty", exp_lvl.size(), 0);
    chk("gen_reset_queue_empty", exp_rst.size(), 0);
    chk("sat_queue_empty", exp_sdone.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
